// File: rtl/i2s_transmitter_dispatcher_if.sv
// Sample-word stream into the I2S dispatcher.
//   s_tdata : word (sample, channel ID, L/R side)
//   s_valid : word present
//   s_ready : word accepted when s_valid & s_ready
interface i2s_transmitter_dispatcher_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_tdata, output s_valid, input s_ready);
    modport slave  (input s_tdata, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_transmitter_dispatcher.sv
// Routes tagged sample words to per-channel L/R pending slots and serialises
// them as I2S master streams driven by one shared bclk/lrclk generator.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_axis            : word stream (slave side), s_ready is combinational
//   bclk, lrclk       : per-channel bit/word clocks (all bits identical)
//   sdata             : per-channel serial data
//   local_error_empty : per-channel underrun pulse at frame start
//   error_empty       : OR of local_error_empty
//   error_id          : one-cycle pulse when a word with an unknown ID is dropped
module i2s_transmitter_dispatcher #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH             = 5,
    parameter int unsigned I2S_TRANSMITTER_NUM  = 4,
    parameter int unsigned I2S_DATA_BIT_WIDTH   = 24,
    parameter int unsigned BCLK_DIV             = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    i2s_transmitter_dispatcher_if.slave    s_axis,
    output logic [I2S_TRANSMITTER_NUM-1:0] bclk,
    output logic [I2S_TRANSMITTER_NUM-1:0] lrclk,
    output logic [I2S_TRANSMITTER_NUM-1:0] sdata,
    output logic [I2S_TRANSMITTER_NUM-1:0] local_error_empty,
    output logic                           error_empty,
    output logic                           error_id
);
    localparam int unsigned NUM   = I2S_TRANSMITTER_NUM;
    localparam int unsigned W     = I2S_DATA_BIT_WIDTH;
    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned IDX_W = ID_WIDTH + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM);

    // Word fields
    logic [C_S_AXIS_TDATA_WIDTH-1:0] word;
    logic [ID_WIDTH-1:0]             word_id;
    logic                            word_side;
    logic [W-1:0]                    word_smp;
    logic                            unused_word;

    assign word        = s_axis.s_tdata;
    assign word_id     = word[24 +: ID_WIDTH];
    assign word_side   = word[31];
    assign word_smp    = word[W-1:0];
    assign unused_word = ^word;

    // Timing generator and per-channel state
    logic [DIV_W-1:0] div_cnt;
    logic             bclk_r;
    logic             lrclk_r;
    logic [5:0]       bit_cnt;
    logic [W-1:0]     pend_l [NUM];
    logic [W-1:0]     pend_r [NUM];
    logic [W-1:0]     act_l  [NUM];
    logic [W-1:0]     act_r  [NUM];
    logic [NUM-1:0]   full_l, full_r, armed;
    logic [NUM-1:0]   sdata_r, lee_r;
    logic             err_empty_r, err_id_r;

    // Combinational decode
    logic             ready_c, fall_c, frame_c, in_data_c, bad_id_c, id_ok_c;
    logic [5:0]       bit_nxt_c;
    logic [4:0]       pos_c, shamt_c;
    logic [W-1:0]     shift_c;
    logic [NUM-1:0]   sel_c, load_c, under_c, wr_l_c, wr_r_c, sd_c;

    always_comb begin
        ready_c   = 1'b1;
        sel_c     = '0;
        load_c    = '0;
        under_c   = '0;
        wr_l_c    = '0;
        wr_r_c    = '0;
        sd_c      = '0;
        shift_c   = '0;
        id_ok_c   = {1'b0, word_id} < NUM_IDX;
        fall_c    = bclk_r && (div_cnt == DIV_LAST);
        bit_nxt_c = bit_cnt + 6'd1;
        frame_c   = fall_c && (bit_nxt_c == 6'd0);
        pos_c     = bit_nxt_c[4:0];
        in_data_c = (pos_c != 5'd0) && (pos_c <= 5'(W));
        shamt_c   = 5'(W) - pos_c;
        bad_id_c  = s_axis.s_valid && !id_ok_c;

        // Unknown IDs never match a channel, so they are always accepted
        for (int i = 0; i < NUM; i++) begin
            if (word_id == ID_WIDTH'(i)) begin
                sel_c[i] = 1'b1;
                ready_c  = word_side ? !full_r[i] : !full_l[i];
            end
        end

        for (int i = 0; i < NUM; i++) begin
            load_c[i]  = frame_c && full_l[i] && full_r[i];
            under_c[i] = frame_c && !(full_l[i] && full_r[i]) && armed[i];
            wr_l_c[i]  = s_axis.s_valid && ready_c && sel_c[i] && !word_side;
            wr_r_c[i]  = s_axis.s_valid && ready_c && sel_c[i] &&  word_side;
            shift_c    = (bit_nxt_c[5] ? act_r[i] : act_l[i]) >> shamt_c;
            sd_c[i]    = in_data_c && shift_c[0];
        end
    end

    assign s_axis.s_ready = ready_c;

    // Load and write never target the same flag in one cycle: load needs both
    // slots full, a write needs its slot empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            bclk_r      <= 1'b0;
            lrclk_r     <= 1'b0;
            bit_cnt     <= 6'd63;
            full_l      <= '0;
            full_r      <= '0;
            armed       <= '0;
            sdata_r     <= '0;
            lee_r       <= '0;
            err_empty_r <= 1'b0;
            err_id_r    <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                pend_l[i] <= '0;
                pend_r[i] <= '0;
                act_l[i]  <= '0;
                act_r[i]  <= '0;
            end
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk_r  <= ~bclk_r;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall_c) begin
                bit_cnt <= bit_nxt_c;
                lrclk_r <= bit_nxt_c[5];
                sdata_r <= sd_c;
            end

            for (int i = 0; i < NUM; i++) begin
                if (load_c[i]) begin
                    act_l[i]  <= pend_l[i];
                    act_r[i]  <= pend_r[i];
                    full_l[i] <= 1'b0;
                    full_r[i] <= 1'b0;
                end else if (frame_c) begin
                    act_l[i] <= '0;
                    act_r[i] <= '0;
                end
                if (wr_l_c[i]) begin
                    pend_l[i] <= word_smp;
                    full_l[i] <= 1'b1;
                    armed[i]  <= 1'b1;
                end
                if (wr_r_c[i]) begin
                    pend_r[i] <= word_smp;
                    full_r[i] <= 1'b1;
                    armed[i]  <= 1'b1;
                end
            end

            lee_r       <= under_c;
            err_empty_r <= |under_c;
            err_id_r    <= bad_id_c;
        end
    end

    assign bclk              = {NUM{bclk_r}};
    assign lrclk             = {NUM{lrclk_r}};
    assign sdata             = sdata_r;
    assign local_error_empty = lee_r;
    assign error_empty       = err_empty_r;
    assign error_id          = err_id_r;
endmodule
